mem_stage: RTL and testbench

- Memory-access pipeline stage sitting between the execute stage and the writeback stage register.
- Passes ALU results through to writeback.
- Performs data-memory loads and stores over a req/ack handshake, stalling upstream while an access is outstanding.
- Produces MEMRd/MEMData/MEMRegWrite, consumed by the writeback stage on the following falling edge of Clk.

---
 rtl/mem_stage_pkg.sv | 48 ++++
 rtl/mem_load_align.sv | 32 +++
 rtl/mem_stage.sv | 197 +++++++++++++++++++
 tb/tb_mem_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings, state type and store-lane helpers for the memory-access stage.
package mem_stage_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  byte_en;
  } store_lanes_t;

  // Lane-replicated write data and byte enables; size 2'b11 behaves as a word.
  function automatic store_lanes_t store_lanes(input logic [1:0]  size,
                                               input logic [1:0]  offset,
                                               input logic [31:0] data);
    store_lanes_t s;
    case (size)
      MEM_BYTE: begin
        s.wdata   = {4{data[7:0]}};
        s.byte_en = 4'b0001 << offset;
      end
      MEM_HALF: begin
        s.wdata   = {2{data[15:0]}};
        s.byte_en = 4'b0011 << offset;
      end
      default: begin
        s.wdata   = data;
        s.byte_en = 4'b1111;
      end
    endcase
    return s;
  endfunction

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      MEM_BYTE: return 1'b1;
      MEM_HALF: return ~offset[0];
      default:  return (offset == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/half lane of a read word and zero- or sign-extends it.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (offset_i)
      2'd0:    byte_lane = rdata_i[7:0];
      2'd1:    byte_lane = rdata_i[15:8];
      2'd2:    byte_lane = rdata_i[23:16];
      default: byte_lane = rdata_i[31:24];
    endcase
    // Halves are only issued at even offsets, so offset[1] picks the lane.
    half_lane = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (size_i)
      MEM_BYTE: data_o = {{24{~unsigned_i & byte_lane[7]}}, byte_lane};
      MEM_HALF: data_o = {{16{~unsigned_i & half_lane[15]}}, half_lane};
      default:  data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: ALU pass-through plus req/ack data-memory loads and stores
// with misalignment detection and an access timeout.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        EXValid,
  input  logic [4:0]  EXRd,
  input  logic [31:0] EXALUResult,
  input  logic [31:0] EXStoreData,
  input  logic        EXRegWrite,
  input  logic        EXMemRead,
  input  logic        EXMemWrite,
  input  logic [1:0]  EXMemSize,
  input  logic        EXMemUnsigned,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [31:0] DMemWData,
  output logic [3:0]  DMemByteEn,
  input  logic        DMemAck,
  input  logic [31:0] DMemRData,
  output logic [4:0]  MEMRd,
  output logic [31:0] MEMData,
  output logic        MEMRegWrite,
  output logic        MEMStall,
  output logic        MEMMisalign,
  output logic        MEMBusError
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       cap_rd_q, cap_rd_d;
  logic             cap_regwrite_q, cap_regwrite_d;
  logic             cap_load_q, cap_load_d;
  logic [1:0]       cap_size_q, cap_size_d;
  logic             cap_unsigned_q, cap_unsigned_d;
  logic [1:0]       cap_off_q, cap_off_d;

  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       byte_en_q, byte_en_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      data_q, data_d;
  logic             regwrite_q, regwrite_d;
  logic             misalign_q, misalign_d;
  logic             bus_error_q, bus_error_d;

  logic [31:0]      load_data;
  store_lanes_t     lanes;

  mem_load_align u_load_align (
    .rdata_i    (DMemRData),
    .offset_i   (cap_off_q),
    .size_i     (cap_size_q),
    .unsigned_i (cap_unsigned_q),
    .data_o     (load_data)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      cap_rd_q       <= '0;
      cap_regwrite_q <= 1'b0;
      cap_load_q     <= 1'b0;
      cap_size_q     <= '0;
      cap_unsigned_q <= 1'b0;
      cap_off_q      <= '0;
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      byte_en_q      <= '0;
      rd_q           <= '0;
      data_q         <= '0;
      regwrite_q     <= 1'b0;
      misalign_q     <= 1'b0;
      bus_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cap_rd_q       <= cap_rd_d;
      cap_regwrite_q <= cap_regwrite_d;
      cap_load_q     <= cap_load_d;
      cap_size_q     <= cap_size_d;
      cap_unsigned_q <= cap_unsigned_d;
      cap_off_q      <= cap_off_d;
      req_q          <= req_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      byte_en_q      <= byte_en_d;
      rd_q           <= rd_d;
      data_q         <= data_d;
      regwrite_q     <= regwrite_d;
      misalign_q     <= misalign_d;
      bus_error_q    <= bus_error_d;
    end
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    cap_rd_d       = cap_rd_q;
    cap_regwrite_d = cap_regwrite_q;
    cap_load_d     = cap_load_q;
    cap_size_d     = cap_size_q;
    cap_unsigned_d = cap_unsigned_q;
    cap_off_d      = cap_off_q;
    req_d          = req_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    byte_en_d      = byte_en_q;
    rd_d           = rd_q;
    data_d         = data_q;
    regwrite_d     = regwrite_q;
    misalign_d     = 1'b0;
    bus_error_d    = 1'b0;
    lanes          = store_lanes(EXMemSize, EXALUResult[1:0], EXStoreData);

    case (state_q)
      IDLE: begin
        if (!EXValid) begin
          regwrite_d = 1'b0;
        end else if (!(EXMemRead || EXMemWrite)) begin
          rd_d       = EXRd;
          data_d     = EXALUResult;
          regwrite_d = EXRegWrite;
        end else if (!is_aligned(EXMemSize, EXALUResult[1:0])) begin
          misalign_d = 1'b1;
          regwrite_d = 1'b0;
        end else begin
          state_d        = ACCESS;
          cnt_d          = '0;
          cap_rd_d       = EXRd;
          cap_regwrite_d = EXRegWrite;
          cap_load_d     = EXMemRead;
          cap_size_d     = EXMemSize;
          cap_unsigned_d = EXMemUnsigned;
          cap_off_d      = EXALUResult[1:0];
          req_d          = 1'b1;
          we_d           = EXMemWrite;
          addr_d         = {EXALUResult[31:2], 2'b00};
          wdata_d        = lanes.wdata;
          byte_en_d      = lanes.byte_en;
          regwrite_d     = 1'b0;
        end
      end
      ACCESS: begin
        // An ack arriving on the last counted cycle still completes normally.
        if (DMemAck) begin
          state_d = IDLE;
          req_d   = 1'b0;
          if (cap_load_q) begin
            rd_d       = cap_rd_q;
            data_d     = load_data;
            regwrite_d = cap_regwrite_q;
          end else begin
            regwrite_d = 1'b0;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d     = IDLE;
          req_d       = 1'b0;
          bus_error_d = 1'b1;
          regwrite_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign DMemReq     = req_q;
  assign DMemWe      = we_q;
  assign DMemAddr    = addr_q;
  assign DMemWData   = wdata_q;
  assign DMemByteEn  = byte_en_q;
  assign MEMRd       = rd_q;
  assign MEMData     = data_q;
  assign MEMRegWrite = regwrite_q;
  assign MEMMisalign = misalign_q;
  assign MEMBusError = bus_error_q;
  assign MEMStall    = (state_q == ACCESS);

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized bench for mem_stage against a transaction-level reference model.
module tb_mem_stage;

  localparam int unsigned TO = 4;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        EXValid;
  logic [4:0]  EXRd;
  logic [31:0] EXALUResult;
  logic [31:0] EXStoreData;
  logic        EXRegWrite;
  logic        EXMemRead;
  logic        EXMemWrite;
  logic [1:0]  EXMemSize;
  logic        EXMemUnsigned;
  logic        DMemReq;
  logic        DMemWe;
  logic [31:0] DMemAddr;
  logic [31:0] DMemWData;
  logic [3:0]  DMemByteEn;
  logic        DMemAck;
  logic [31:0] DMemRData;
  logic [4:0]  MEMRd;
  logic [31:0] MEMData;
  logic        MEMRegWrite;
  logic        MEMStall;
  logic        MEMMisalign;
  logic        MEMBusError;

  int errors = 0;
  int checks = 0;

  // Architectural view of the writeback-facing registers.
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .Rst(Rst), .EXValid(EXValid), .EXRd(EXRd), .EXALUResult(EXALUResult),
    .EXStoreData(EXStoreData), .EXRegWrite(EXRegWrite), .EXMemRead(EXMemRead),
    .EXMemWrite(EXMemWrite), .EXMemSize(EXMemSize), .EXMemUnsigned(EXMemUnsigned),
    .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr), .DMemWData(DMemWData),
    .DMemByteEn(DMemByteEn), .DMemAck(DMemAck), .DMemRData(DMemRData), .MEMRd(MEMRd),
    .MEMData(MEMData), .MEMRegWrite(MEMRegWrite), .MEMStall(MEMStall),
    .MEMMisalign(MEMMisalign), .MEMBusError(MEMBusError)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] addr,
                                           input int size, input bit uns);
    logic [31:0] v;
    v = rdata >> (8 * (addr % 4));
    if (size == 0) begin
      v = v & 32'hFF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (size == 1) begin
      v = v & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_byte_en(input logic [31:0] addr, input int size);
    if (size == 0) return 32'd1 << (addr % 4);
    if (size == 1) return 32'd3 << (addr % 4);
    return 32'd15;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input int size);
    if (size == 0) return (d & 32'hFF) * 32'h0101_0101;
    if (size == 1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic bit ref_misaligned(input logic [31:0] addr, input int size);
    if (size == 0) return 1'b0;
    if (size == 1) return (addr % 2) != 0;
    return (addr % 4) != 0;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, ".req"}, 32'(DMemReq), 32'd0);
    chk({tag, ".we"}, 32'(DMemWe), 32'd0);
    chk({tag, ".addr"}, DMemAddr, 32'd0);
    chk({tag, ".wdata"}, DMemWData, 32'd0);
    chk({tag, ".be"}, 32'(DMemByteEn), 32'd0);
    chk({tag, ".rd"}, 32'(MEMRd), 32'd0);
    chk({tag, ".data"}, MEMData, 32'd0);
    chk({tag, ".rw"}, 32'(MEMRegWrite), 32'd0);
    chk({tag, ".mis"}, 32'(MEMMisalign), 32'd0);
    chk({tag, ".berr"}, 32'(MEMBusError), 32'd0);
    chk({tag, ".stall"}, 32'(MEMStall), 32'd0);
  endtask

  task automatic bubble(input string tag);
    EXValid = 1'b0;
    EXMemRead = 1'b0;
    EXMemWrite = 1'b0;
    DMemAck = 1'b0;
    step();
    chk({tag, ".bub.rw"}, 32'(MEMRegWrite), 32'd0);
    chk({tag, ".bub.rd"}, 32'(MEMRd), 32'(exp_rd));
    chk({tag, ".bub.data"}, MEMData, exp_data);
    chk({tag, ".bub.mis"}, 32'(MEMMisalign), 32'd0);
    chk({tag, ".bub.berr"}, 32'(MEMBusError), 32'd0);
    chk({tag, ".bub.req"}, 32'(DMemReq), 32'd0);
  endtask

  task automatic do_alu(input string tag, input logic [4:0] rd, input logic [31:0] res,
                        input bit regwr);
    EXValid = 1'b1; EXRd = rd; EXALUResult = res; EXRegWrite = regwr;
    EXMemRead = 1'b0; EXMemWrite = 1'b0; EXStoreData = $urandom;
    step();
    exp_rd = rd; exp_data = res;
    chk({tag, ".rd"}, 32'(MEMRd), 32'(rd));
    chk({tag, ".data"}, MEMData, res);
    chk({tag, ".rw"}, 32'(MEMRegWrite), 32'(regwr));
    chk({tag, ".stall"}, 32'(MEMStall), 32'd0);
  endtask

  // Ack is sampled at the delay-th edge after the request edge; delay > TO means no ack.
  task automatic do_mem(input string tag, input bit is_load, input logic [31:0] addr,
                        input int size, input bit uns, input logic [31:0] sdata,
                        input logic [4:0] rd, input bit regwr, input int delay,
                        input logic [31:0] rdata);
    bit done;
    EXValid = 1'b1; EXRd = rd; EXALUResult = addr; EXStoreData = sdata; EXRegWrite = regwr;
    EXMemRead = is_load; EXMemWrite = !is_load; EXMemSize = 2'(size); EXMemUnsigned = uns;
    DMemAck = 1'b0; DMemRData = $urandom;
    step();
    if (ref_misaligned(addr, size)) begin
      chk({tag, ".mis"}, 32'(MEMMisalign), 32'd1);
      chk({tag, ".mis.req"}, 32'(DMemReq), 32'd0);
      chk({tag, ".mis.rw"}, 32'(MEMRegWrite), 32'd0);
      chk({tag, ".mis.stall"}, 32'(MEMStall), 32'd0);
      bubble(tag);
      return;
    end
    chk({tag, ".req"}, 32'(DMemReq), 32'd1);
    chk({tag, ".we"}, 32'(DMemWe), 32'(!is_load));
    chk({tag, ".addr"}, DMemAddr, addr & 32'hFFFF_FFFC);
    chk({tag, ".be"}, 32'(DMemByteEn), ref_byte_en(addr, size));
    if (!is_load) chk({tag, ".wdata"}, DMemWData, ref_wdata(sdata, size));
    chk({tag, ".stall"}, 32'(MEMStall), 32'd1);
    chk({tag, ".rw0"}, 32'(MEMRegWrite), 32'd0);
    done = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      DMemAck = (k == delay);
      DMemRData = (k == delay) ? rdata : $urandom;
      step();
      if (k == delay) begin
        if (is_load) begin
          exp_rd = rd;
          exp_data = ref_load(rdata, addr, size, uns);
        end
        chk({tag, ".ack.req"}, 32'(DMemReq), 32'd0);
        chk({tag, ".ack.stall"}, 32'(MEMStall), 32'd0);
        chk({tag, ".ack.rw"}, 32'(MEMRegWrite), 32'(is_load && regwr));
        chk({tag, ".ack.data"}, MEMData, exp_data);
        chk({tag, ".ack.rd"}, 32'(MEMRd), 32'(exp_rd));
        chk({tag, ".ack.berr"}, 32'(MEMBusError), 32'd0);
        done = 1'b1;
        break;
      end else if (k == TO) begin
        chk({tag, ".to.berr"}, 32'(MEMBusError), 32'd1);
        chk({tag, ".to.req"}, 32'(DMemReq), 32'd0);
        chk({tag, ".to.stall"}, 32'(MEMStall), 32'd0);
        chk({tag, ".to.rw"}, 32'(MEMRegWrite), 32'd0);
        done = 1'b1;
        break;
      end else begin
        chk({tag, ".wait.stall"}, 32'(MEMStall), 32'd1);
        chk({tag, ".wait.req"}, 32'(DMemReq), 32'd1);
        chk({tag, ".wait.addr"}, DMemAddr, addr & 32'hFFFF_FFFC);
        chk({tag, ".wait.berr"}, 32'(MEMBusError), 32'd0);
      end
    end
    if (!done) chk({tag, ".bound"}, 32'd0, 32'd1);
    bubble(tag);
  endtask

  initial begin
    Rst = 1'b1; EXValid = 1'b0; EXRd = '0; EXALUResult = '0; EXStoreData = '0;
    EXRegWrite = 1'b0; EXMemRead = 1'b0; EXMemWrite = 1'b0; EXMemSize = '0;
    EXMemUnsigned = 1'b0; DMemAck = 1'b0; DMemRData = '0;
    exp_rd = '0; exp_data = '0;
    step();
    step();
    chk_all_zero("reset");
    Rst = 1'b0;

    do_alu("alu", 5'd5, 32'h1234, 1'b1);
    bubble("alu");
    do_mem("ldw", 1'b1, 32'h100, 2, 1'b0, 32'h0, 5'd7, 1'b1, 3, 32'hDEAD_BEEF);
    do_mem("ldb_s", 1'b1, 32'h103, 0, 1'b0, 32'h0, 5'd8, 1'b1, 1, 32'h8000_0000);
    do_mem("ldb_u", 1'b1, 32'h103, 0, 1'b1, 32'h0, 5'd9, 1'b1, 2, 32'h8000_0000);
    do_mem("sth", 1'b0, 32'h202, 1, 1'b0, 32'h0000_ABCD, 5'd3, 1'b0, 2, 32'h0);
    do_mem("misw", 1'b1, 32'h101, 2, 1'b0, 32'h0, 5'd4, 1'b1, 1, 32'h0);
    do_mem("tmo", 1'b1, 32'h300, 2, 1'b0, 32'h0, 5'd6, 1'b1, 99, 32'h0);
    do_mem("ack_at_to", 1'b1, 32'h304, 1, 1'b0, 32'h0, 5'd10, 1'b1, TO, 32'h1234_F00D);

    // Reset in the middle of an outstanding load, then a stray ack.
    EXValid = 1'b1; EXRd = 5'd11; EXALUResult = 32'h400; EXRegWrite = 1'b1;
    EXMemRead = 1'b1; EXMemWrite = 1'b0; EXMemSize = 2'b10; DMemAck = 1'b0;
    step();
    chk("rst_mid.req", 32'(DMemReq), 32'd1);
    step();
    Rst = 1'b1;
    step();
    exp_rd = '0; exp_data = '0;
    chk_all_zero("rst_mid");
    Rst = 1'b0; EXValid = 1'b0; DMemAck = 1'b1; DMemRData = 32'hCAFE_F00D;
    step();
    DMemAck = 1'b0;
    chk("late_ack.rw", 32'(MEMRegWrite), 32'd0);
    chk("late_ack.data", MEMData, 32'd0);
    chk("late_ack.req", 32'(DMemReq), 32'd0);
    chk("late_ack.stall", 32'(MEMStall), 32'd0);

    for (int n = 0; n < 60; n++) begin
      int op;
      op = int'($urandom_range(0, 2));
      if (op == 0) begin
        do_alu("r_alu", 5'($urandom), $urandom, 1'($urandom));
        if ($urandom_range(0, 1) == 1) bubble("r_alu");
      end else begin
        do_mem(op == 1 ? "r_ld" : "r_st", op == 1, $urandom, int'($urandom_range(0, 3)),
               1'($urandom), $urandom, 5'($urandom), 1'($urandom),
               int'($urandom_range(1, TO + 2)), $urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
